// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, default widths and
// timing helpers for the systolic array sequencer.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int SA_N   = 4;
    localparam int SA_AW  = 16;
    localparam int SA_IW  = 16;
    localparam int SA_KW  = 16;
    localparam int SA_LAT = 1;

    // Last read to final product landing in PE(N-1,N-1).
    function automatic int drain_cycles(int n, int lat);
        return 2 * (n - 1) + lat + 1;
    endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// sa_seq_ctrl_if: control handshake, instruction fetch and
// A/B/PE/output-bank signals of the array sequencer.
interface sa_seq_ctrl_if #(
    parameter int N  = 4,
    parameter int AW = 16,
    parameter int IW = 16,
    parameter int KW = 16
);
    logic            ap_start;
    logic            ap_done;
    logic            ap_idle;
    logic [IW-1:0]   instr_addr;
    logic [KW-1:0]   instr_data;
    logic [N-1:0]    a_rd_en;
    logic [N*AW-1:0] a_rd_addr;
    logic [N-1:0]    b_rd_en;
    logic [N*AW-1:0] b_rd_addr;
    logic            pe_clear;
    logic            pe_en;
    logic            out_wr_en;
    logic [AW-1:0]   out_base;

    modport master (
        input  ap_start, instr_data,
        output ap_done, ap_idle, instr_addr,
        output a_rd_en, a_rd_addr,
        output b_rd_en, b_rd_addr,
        output pe_clear, pe_en,
        output out_wr_en, out_base
    );

    modport slave (
        output ap_start, instr_data,
        input  ap_done, ap_idle, instr_addr,
        input  a_rd_en, a_rd_addr,
        input  b_rd_en, b_rd_addr,
        input  pe_clear, pe_en,
        input  out_wr_en, out_base
    );
endinterface

// File: rtl/sa_lane_addr_gen.sv
// sa_lane_addr_gen: skewed A/B read address for one lane
// at stream step t; zero enable and address when idle.
module sa_lane_addr_gen #(
    parameter int LANE = 0,
    parameter int N    = 4,
    parameter int AW   = 16,
    parameter int KW   = 16,
    parameter int TW   = 17
) (
    input  logic [TW-1:0] t_i,
    input  logic [KW-1:0] k_i,
    input  logic [AW-1:0] a_ptr_i,
    input  logic [AW-1:0] b_ptr_i,
    output logic          rd_en_o,
    output logic [AW-1:0] a_addr_o,
    output logic [AW-1:0] b_addr_o
);
    localparam int TX = TW + 1;
    localparam logic [TX-1:0] LO = TX'(LANE);

    logic [TX-1:0] t_x;
    logic [TX-1:0] hi;
    logic [AW-1:0] off;
    logic          act;

    always_comb begin
        t_x = {1'b0, t_i};
        hi  = TX'(k_i) + LO;
        act = (t_x >= LO) && (t_x < hi);
        off = AW'(t_i - TW'(LANE));
        rd_en_o  = act;
        a_addr_o = '0;
        b_addr_o = '0;
        if (act) begin
            a_addr_o = a_ptr_i + AW'(LANE) * AW'(k_i) + off;
            b_addr_o = b_ptr_i + off * AW'(N) + AW'(LANE);
        end
    end
endmodule

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: program sequencer for an N x N output-stationary
// systolic array; fetch K, stream skewed reads, drain, write.
module sa_seq_ctrl
    import sa_pkg::*;
#(
    parameter int N       = SA_N,
    parameter int AW      = SA_AW,
    parameter int IW      = SA_IW,
    parameter int KW      = SA_KW,
    parameter int MEM_LAT = SA_LAT
) (
    input  logic          clk,
    input  logic          rst,
    sa_seq_ctrl_if.master bus
);
    localparam int TW = KW + 1;
    localparam int D  = drain_cycles(N, MEM_LAT);

    state_t          state_q, state_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [AW-1:0]   a_ptr_q, a_ptr_d;
    logic [AW-1:0]   b_ptr_q, b_ptr_d;
    logic [AW-1:0]   base_q, base_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    en_q;
    logic [N*AW-1:0] a_addr_q;
    logic [N*AW-1:0] b_addr_q;

    logic [N-1:0]    en_w;
    logic [N*AW-1:0] a_addr_w;
    logic [N*AW-1:0] b_addr_w;
    logic [AW-1:0]   kn;
    logic            in_stream;

    assign kn        = AW'(k_q) * AW'(N);
    assign in_stream = (state_d == STREAM);

    // Lanes see next-cycle t/K/pointers so the registered
    // addresses line up with the STREAM state they belong to.
    for (genvar i = 0; i < N; i++) begin : g_lane
        sa_lane_addr_gen #(
            .LANE (i),
            .N    (N),
            .AW   (AW),
            .KW   (KW),
            .TW   (TW)
        ) u_gen (
            .t_i      (cnt_d),
            .k_i      (k_d),
            .a_ptr_i  (a_ptr_d),
            .b_ptr_i  (b_ptr_d),
            .rd_en_o  (en_w[i]),
            .a_addr_o (a_addr_w[i*AW +: AW]),
            .b_addr_o (b_addr_w[i*AW +: AW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            base_q   <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            en_q     <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            base_q   <= base_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            en_q     <= in_stream ? en_w : '0;
            a_addr_q <= in_stream ? a_addr_w : '0;
            b_addr_q <= in_stream ? b_addr_w : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        base_d  = base_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ap_start) begin
                    state_d = FETCH;
                    instr_d = '0;
                    a_ptr_d = '0;
                    b_ptr_d = '0;
                    base_d  = '0;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                k_d     = bus.instr_data;
                cnt_d   = '0;
                state_d = (bus.instr_data == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (cnt_q == TW'(k_q) + TW'(N - 2)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == TW'(D - 1)) begin
                    cnt_d   = '0;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                state_d = FETCH;
                base_d  = base_q + AW'(N * N);
                a_ptr_d = a_ptr_q + kn;
                b_ptr_d = b_ptr_q + kn;
                instr_d = instr_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ap_idle   = (state_q == IDLE);
        bus.ap_done   = (state_q == DONE);
        bus.pe_clear  = (state_q == DECODE) &&
                        (bus.instr_data != '0);
        bus.pe_en     = (state_q == STREAM) ||
                        (state_q == DRAIN);
        bus.out_wr_en = (state_q == WRITE);
    end

    assign bus.instr_addr = instr_q;
    assign bus.out_base   = base_q;
    assign bus.a_rd_en    = en_q;
    assign bus.b_rd_en    = en_q;
    assign bus.a_rd_addr  = a_addr_q;
    assign bus.b_rd_addr  = b_addr_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: program table, directed corner sequences and
// randomised programs against a cycle-trace reference model.
module tb_sa_seq_ctrl;
    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int IW  = 16;
    localparam int KW  = 16;
    localparam int LAT = 1;
    localparam int D   = 2 * (N - 1) + LAT + 1;

    typedef struct packed {
        logic            idle;
        logic            done;
        logic            clr;
        logic            pen;
        logic            wr;
        logic [IW-1:0]   ia;
        logic [AW-1:0]   base;
        logic [N-1:0]    aen;
        logic [N-1:0]    ben;
        logic [N*AW-1:0] aad;
        logic [N*AW-1:0] bad;
    } rec_t;

    typedef struct {
        int k0, k1, k2, k3;
        int done_c, wr_n, base, pen_n, en_n, clr_n;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nerr = 0;
    int   nchk = 0;

    logic [KW-1:0]   prog   [64];
    logic [N*AW-1:0] obs_a  [64];
    logic [N*AW-1:0] obs_b  [64];
    logic [N-1:0]    obs_en [64];
    rec_t            expq   [$];

    sa_seq_ctrl_if #(.N(N), .AW(AW), .IW(IW), .KW(KW)) bus ();

    sa_seq_ctrl #(
        .N(N), .AW(AW), .IW(IW), .KW(KW), .MEM_LAT(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.instr_data <= prog[bus.instr_addr[5:0]];

    task automatic chk(input string nm,
                       input logic [255:0] act,
                       input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic rec_t blank(input int ia, input int base);
        rec_t r;
        r      = '0;
        r.ia   = IW'(ia);
        r.base = AW'(base);
        return r;
    endfunction

    function automatic rec_t sample();
        rec_t r;
        r.idle = bus.ap_idle;
        r.done = bus.ap_done;
        r.clr  = bus.pe_clear;
        r.pen  = bus.pe_en;
        r.wr   = bus.out_wr_en;
        r.ia   = bus.instr_addr;
        r.base = bus.out_base;
        r.aen  = bus.a_rd_en;
        r.ben  = bus.b_rd_en;
        r.aad  = bus.a_rd_addr;
        r.bad  = bus.b_rd_addr;
        return r;
    endfunction

    // Expected per-cycle trace from cycle 1 (first FETCH) up to
    // and including the IDLE cycle following DONE.
    function automatic void build();
        int   idx, ap, bp, base, k;
        rec_t r;
        idx  = 0;
        ap   = 0;
        bp   = 0;
        base = 0;
        expq.delete();
        while (1) begin
            k = int'(prog[idx % 64]);
            r = blank(idx, base);
            expq.push_back(r);
            r.clr = (k != 0);
            expq.push_back(r);
            if (k == 0) begin
                r      = blank(idx, base);
                r.done = 1'b1;
                expq.push_back(r);
                r      = blank(idx, base);
                r.idle = 1'b1;
                expq.push_back(r);
                break;
            end
            for (int t = 0; t < k + N - 1; t++) begin
                r     = blank(idx, base);
                r.pen = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (t >= i && t < k + i) begin
                        r.aen[i] = 1'b1;
                        r.ben[i] = 1'b1;
                        r.aad[i*AW +: AW] = AW'(ap + i * k + t - i);
                        r.bad[i*AW +: AW] = AW'(bp + (t - i) * N + i);
                    end
                end
                expq.push_back(r);
            end
            for (int d = 0; d < D; d++) begin
                r     = blank(idx, base);
                r.pen = 1'b1;
                expq.push_back(r);
            end
            r    = blank(idx, base);
            r.wr = 1'b1;
            expq.push_back(r);
            base += N * N;
            ap   += k * N;
            bp   += k * N;
            idx++;
        end
    endfunction

    task automatic load(input int k0, input int k1,
                        input int k2, input int k3);
        foreach (prog[i]) prog[i] = '0;
        prog[0] = KW'(k0);
        prog[1] = KW'(k1);
        prog[2] = KW'(k2);
        prog[3] = KW'(k3);
    endtask

    // Called at a negedge with the DUT idle; that cycle is cycle 0.
    task automatic run_prog(input bit noise, input string nm);
        rec_t o;
        build();
        bus.ap_start = 1'b1;
        for (int j = 0; j < expq.size(); j++) begin
            @(negedge clk);
            o = sample();
            if (j + 1 < 64) begin
                obs_a[j+1]  = o.aad;
                obs_b[j+1]  = o.bad;
                obs_en[j+1] = o.aen;
            end
            chk($sformatf("%s cyc%0d", nm, j + 1), o, expq[j]);
            bus.ap_start = (noise && j + 1 < expq.size()) ?
                           1'($urandom_range(1)) : 1'b0;
        end
    endtask

    task automatic run_row(input row_t rw, input int n);
        int dc, wr, pen, en, clr, lb;
        dc  = -1;
        wr  = 0;
        pen = 0;
        en  = 0;
        clr = 0;
        lb  = -1;
        load(rw.k0, rw.k1, rw.k2, rw.k3);
        bus.ap_start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            bus.ap_start = 1'b0;
            if (bus.pe_en) pen++;
            if (bus.pe_clear) clr++;
            if (bus.out_wr_en) begin
                wr++;
                lb = int'(bus.out_base);
            end
            en += $countones(bus.a_rd_en);
            if (bus.ap_done) begin
                dc = c;
                break;
            end
        end
        @(negedge clk);
        chk($sformatf("row%0d done_cycle", n), dc, rw.done_c);
        chk($sformatf("row%0d writes", n), wr, rw.wr_n);
        chk($sformatf("row%0d last_base", n), lb, rw.base);
        chk($sformatf("row%0d pe_en_cycles", n), pen, rw.pen_n);
        chk($sformatf("row%0d lane_reads", n), en, rw.en_n);
        chk($sformatf("row%0d clears", n), clr, rw.clr_n);
    endtask

    initial begin
        row_t rows [5];
        rec_t er;
        int   cnt;
        int   len;

        bus.ap_start = 1'b0;
        foreach (prog[i]) prog[i] = '0;
        repeat (3) @(negedge clk);
        er      = '0;
        er.idle = 1'b1;
        chk("reset_state", sample(), er);
        rst = 1'b0;

        rows[0] = '{4, 0, 0, 0, 21, 1, 0, 15, 16, 1};
        rows[1] = '{0, 0, 0, 0, 3, 0, -1, 0, 0, 0};
        rows[2] = '{2, 3, 0, 0, 36, 2, 16, 27, 20, 2};
        rows[3] = '{1, 0, 0, 0, 18, 1, 0, 12, 4, 1};
        rows[4] = '{1, 1, 1, 0, 48, 3, 32, 36, 12, 3};
        for (int r = 0; r < 5; r++) run_row(rows[r], r);

        load(4, 0, 0, 0);
        run_prog(1'b0, "k4");
        for (int t = 2; t <= 5; t++) begin
            chk($sformatf("k4 lane2 a t%0d", t),
                obs_a[3+t][2*AW +: AW], 8 + t - 2);
            chk($sformatf("k4 lane2 b t%0d", t),
                obs_b[3+t][2*AW +: AW], 2 + 4 * (t - 2));
        end

        load(2, 3, 0, 0);
        run_prog(1'b1, "k23");
        for (int t = 0; t < 3; t++)
            chk($sformatf("k23 tile2 lane0 a t%0d", t),
                obs_a[19+t][AW-1:0], 8 + t);

        load(0, 0, 0, 0);
        run_prog(1'b0, "k0");

        load(1, 0, 0, 0);
        run_prog(1'b0, "k1");
        for (int t = 0; t < N; t++)
            chk($sformatf("k1 lane_en t%0d", t), obs_en[3+t], 1 << t);
        chk("k1 lane_en after", obs_en[3+N], 0);

        load(4, 0, 0, 0);
        bus.ap_start = 1'b1;
        @(negedge clk);
        bus.ap_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid pe_en before", bus.pe_en, 1);
        rst = 1'b1;
        @(negedge clk);
        er      = '0;
        er.idle = 1'b1;
        chk("rst_mid state", sample(), er);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_wr_en || bus.ap_done || !bus.ap_idle) cnt++;
        end
        chk("rst_mid quiet", cnt, 0);

        load(0, 0, 0, 0);
        bus.ap_start = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold done1", bus.ap_done, 1);
        @(negedge clk);
        chk("hold idle", bus.ap_idle, 1);
        @(negedge clk);
        chk("hold refetch", {bus.ap_idle, bus.instr_addr}, 0);
        bus.ap_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold done2", bus.ap_done, 1);
        @(negedge clk);
        chk("hold end idle", bus.ap_idle, 1);

        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 3);
            foreach (prog[i]) prog[i] = '0;
            for (int i = 0; i < len; i++)
                prog[i] = KW'($urandom_range(1, 7));
            run_prog(1'($urandom_range(1)), $sformatf("rnd%0d", r));
        end

        load(17000, 2, 0, 0);
        run_prog(1'b0, "wrap");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
